mem_unit_p: RTL and testbench

Parametrised, clocked successor to the lab combinational memory. It holds a separate instruction memory (IMEM) and data memory (DMEM).
- IMEM has a registered fetch port and a boot-time load port.
- DMEM has a req/ack data port with a configurable wait-state counter.
- The block sits between the datapath (PC/address mux, AC) and the control FSM.
- It adds range checking, a handshake and reset-time DMEM initialisation.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 61 ++++++
 rtl/mem_unit_p.sv | 153 +++++++++++++++
 tb/tb_mem_unit_p.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, default sizes and the address range check for the memory unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dstate_t;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_ADDR_W     = 12;
  localparam int unsigned DEF_DMEM_DEPTH = 16;
  localparam int unsigned DEF_IMEM_DEPTH = 12;
  localparam int unsigned CNT_W          = 4;

  // Unsigned compare of a zero-extended address against a word count.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word array with synchronous write, registered read (read-before-write)
// and a range guard on both ports. Optional async reset loads mem[i] = i.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DEPTH    = DEF_DMEM_DEPTH,
  parameter bit          RST_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = we && in_range(32'(waddr), DEPTH);
  assign rd_ok = in_range(32'(raddr), DEPTH);

  generate
    if (RST_INIT) begin : g_init
      // Storage with reset-time index pattern; out-of-range writes dropped.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[IDX_W'(i)] <= DATA_W'(i);
          end
        end else if (wr_ok) begin
          mem[waddr[IDX_W-1:0]] <= wdata;
        end
      end
    end else begin : g_noinit
      // Storage without reset; out-of-range writes dropped.
      always_ff @(posedge clk) begin
        if (wr_ok) begin
          mem[waddr[IDX_W-1:0]] <= wdata;
        end
      end
    end
  endgenerate

  // Registered read; old contents on same-address write, zero when out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_ok ? mem[raddr[IDX_W-1:0]] : '0;
    end
  end

endmodule

// File: rtl/mem_unit_p.sv
// Clocked instruction/data memory unit: registered IMEM fetch with load port,
// req/ack DMEM port with programmable wait states and range error.
module mem_unit_p
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DMEM_DEPTH = DEF_DMEM_DEPTH,
  parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int unsigned WAIT_CYC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              d_busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  dstate_t           state, nstate;
  logic [CNT_W-1:0]  cnt;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              capture;
  logic              access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_ok;
  logic              wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              err_q;
  logic [DATA_W-1:0] dm_rdata;

  mem_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (IMEM_DEPTH),
    .RST_INIT(1'b0)
  ) u_imem (
    .clk  (clk),
    .rst  (rst),
    .we   (ld_en),
    .waddr(ld_addr),
    .wdata(ld_data),
    .re   (if_req),
    .raddr(if_addr),
    .rdata(if_data)
  );

  // Fetch valid follows the request by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
    end else begin
      if_valid <= if_req;
    end
  end

  // Next state, capture decision and the address/data used on the access edge.
  always_comb begin
    nstate  = state;
    capture = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (d_req) begin
          capture = 1'b1;
          nstate  = (WAIT_CYC == 0) ? DONE : WAIT;
        end else begin
          nstate = IDLE;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          nstate = DONE;
        end
      end
      default: nstate = IDLE;
    endcase
    // The access happens on every edge that enters DONE; with no wait states
    // that is the capturing edge itself, so the live inputs are used there.
    access    = (nstate == DONE);
    acc_we    = capture ? d_we    : cap_we;
    acc_addr  = capture ? d_addr  : cap_addr;
    acc_wdata = capture ? d_wdata : cap_wdata;
    acc_ok    = in_range(32'(acc_addr), DMEM_DEPTH);
  end

  // State register, request capture, wait counter and completion status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      wb_sel    <= 1'b0;
      wb_data   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= nstate;
      if (capture) begin
        cap_we    <= d_we;
        cap_addr  <= d_addr;
        cap_wdata <= d_wdata;
        cnt       <= CNT_W'(WAIT_CYC);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access) begin
        wb_sel  <= acc_we;
        wb_data <= acc_ok ? acc_wdata : '0;
        err_q   <= !acc_ok;
      end
    end
  end

  mem_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DMEM_DEPTH),
    .RST_INIT(1'b1)
  ) u_dmem (
    .clk  (clk),
    .rst  (rst),
    .we   (access && acc_we),
    .waddr(acc_addr),
    .wdata(acc_wdata),
    .re   (access && !acc_we),
    .raddr(acc_addr),
    .rdata(dm_rdata)
  );

  // Reads are held in the array's output register; writes return their own
  // data (zero when out of range) from a separate holding register.
  assign d_rdata = wb_sel ? wb_data : dm_rdata;
  assign d_ack   = (state == DONE);
  assign d_busy  = (state == WAIT);
  assign d_err   = (state == DONE) && err_q;

endmodule

// File: tb/tb_mem_unit_p.sv
// Bench for mem_unit_p: three instances (0, 3 and 2 wait states) share the
// fetch/load inputs and own their data ports. A transaction-level model is
// compared against every output on each falling edge.
module tb_mem_unit_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [15:0] ld_data;

  logic        ifv   [3];
  logic [15:0] ifd   [3];
  logic        dreq  [3];
  logic        dwe   [3];
  logic [11:0] daddr [3];
  logic [15:0] dwd   [3];
  logic        dack  [3];
  logic        derr  [3];
  logic        dbusy [3];
  logic [15:0] drd   [3];

  int total = 0;
  int bad   = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_unit_p #(
        .DATA_W    (16),
        .ADDR_W    (12),
        .DMEM_DEPTH(16),
        .IMEM_DEPTH(12),
        .WAIT_CYC  ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
      ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_valid(ifv[g]),
        .if_data (ifd[g]),
        .d_req   (dreq[g]),
        .d_we    (dwe[g]),
        .d_addr  (daddr[g]),
        .d_wdata (dwd[g]),
        .d_ack   (dack[g]),
        .d_rdata (drd[g]),
        .d_err   (derr[g]),
        .d_busy  (dbusy[g]),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
      );
    end
  endgenerate

  function automatic int wcof(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mdm [3][16];
  logic [15:0] mim [12];
  logic        pend [3];
  int          rem  [3];
  logic        t_we [3];
  logic [11:0] t_a  [3];
  logic [15:0] t_d  [3];
  logic        e_ack [3];
  logic        e_busy[3];
  logic        e_err [3];
  logic [15:0] e_rd  [3];
  logic        e_ifv;
  logic [15:0] e_ifd;
  logic        fin;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pend[i] = 1'b0; rem[i] = 0;
        e_ack[i] = 1'b0; e_busy[i] = 1'b0; e_err[i] = 1'b0; e_rd[i] = '0;
        for (int a = 0; a < 16; a++) mdm[i][a] = 16'(a);
      end
      e_ifv = 1'b0;
      e_ifd = '0;
    end else begin
      if (if_req) e_ifd = (if_addr < 12'd12) ? mim[if_addr[3:0]] : 16'h0000;
      e_ifv = if_req;
      if (ld_en && ld_addr < 12'd12) mim[ld_addr[3:0]] = ld_data;
      for (int i = 0; i < 3; i++) begin
        fin = 1'b0;
        e_ack[i] = 1'b0;
        e_err[i] = 1'b0;
        if (pend[i]) begin
          rem[i] = rem[i] - 1;
          fin = (rem[i] == 0);
        end else if (dreq[i]) begin
          t_we[i] = dwe[i]; t_a[i] = daddr[i]; t_d[i] = dwd[i];
          rem[i] = wcof(i);
          pend[i] = 1'b1;
          fin = (rem[i] == 0);
        end
        if (fin) begin
          pend[i] = 1'b0;
          e_ack[i] = 1'b1;
          if (t_a[i] < 12'd16) begin
            if (t_we[i]) begin
              mdm[i][t_a[i][3:0]] = t_d[i];
              e_rd[i] = t_d[i];
            end else begin
              e_rd[i] = mdm[i][t_a[i][3:0]];
            end
          end else begin
            e_rd[i] = '0;
            e_err[i] = 1'b1;
          end
        end
        e_busy[i] = pend[i];
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("if_valid", i, 32'(ifv[i]),   32'(e_ifv));
      chk("if_data",  i, 32'(ifd[i]),   32'(e_ifd));
      chk("d_ack",    i, 32'(dack[i]),  32'(e_ack[i]));
      chk("d_busy",   i, 32'(dbusy[i]), 32'(e_busy[i]));
      chk("d_err",    i, 32'(derr[i]),  32'(e_err[i]));
      chk("d_rdata",  i, 32'(drd[i]),   32'(e_rd[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input int i, input logic we, input logic [11:0] a, input logic [15:0] wd,
                        output int lat, output int nb, output logic [15:0] rd, output logic er);
    lat = 0; nb = 0; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    dreq[i] = 1'b1; dwe[i] = we; daddr[i] = a; dwd[i] = wd;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (dack[i]) break;
      if (dbusy[i]) begin
        nb++;
        daddr[i] = ~a;
        dwd[i]   = ~wd;
      end
    end
    rd = drd[i];
    er = derr[i];
    dreq[i] = 1'b0; dwe[i] = 1'b0; daddr[i] = '0; dwd[i] = '0;
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [11:0] a, input logic [15:0] exp, input string nm);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    @(posedge clk); #1;
    if_req = 1'b0;
    chk({nm, "_valid"}, 0, 32'(ifv[0]), 32'h1);
    chk({nm, "_data"},  0, 32'(ifd[0]), 32'(exp));
  endtask

  int          lat, nb, n;
  logic [15:0] rd;
  logic        er;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 3; i++) begin
      dreq[i] = 1'b0; dwe[i] = 1'b0; daddr[i] = '0; dwd[i] = '0;
    end
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rdata", 1, 32'(drd[1]), 32'h0);
    chk("mdl_rst_dmem7", 1, 32'(mdm[1][7]), 32'h7);

    // Fill IMEM with a known pattern, then the specific words.
    for (int k = 0; k < 12; k++) load(12'(k), 16'h0100 + 16'(k));
    load(12'd0,  16'h000C);
    load(12'd11, 16'hB00A);
    fetch(12'd11, 16'hB00A, "fetch11");

    // Same-cycle load and fetch of one address: old contents come back.
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 12'd11; ld_data = 16'h1234;
    if_req = 1'b1; if_addr = 12'd11;
    @(posedge clk); #1;
    ld_en = 1'b0; if_req = 1'b0;
    chk("rbw_data", 0, 32'(ifd[0]), 32'hB00A);
    @(posedge clk); #1;
    chk("fetch_drop_valid", 0, 32'(ifv[0]), 32'h0);
    chk("fetch_hold_data",  0, 32'(ifd[0]), 32'hB00A);
    fetch(12'd11, 16'h1234, "fetch11_new");
    fetch(12'd0,  16'h000C, "fetch0");
    fetch(12'd12, 16'h0000, "fetch_oor");

    // No wait states: read every DMEM word.
    for (int a = 0; a < 16; a++) begin
      access(0, 1'b0, 12'(a), 16'h0, lat, nb, rd, er);
      chk("w0_lat", 0, 32'(lat), 32'd1);
      chk("w0_rd",  0, 32'(rd),  32'(a));
      chk("w0_err", 0, 32'(er),  32'd0);
    end

    // Three wait states: write then read back.
    access(1, 1'b1, 12'd5, 16'hBEEF, lat, nb, rd, er);
    chk("w3_wr_lat",  1, 32'(lat), 32'd4);
    chk("w3_wr_busy", 1, 32'(nb),  32'd3);
    chk("w3_wr_rd",   1, 32'(rd),  32'hBEEF);
    access(1, 1'b0, 12'd5, 16'h0, lat, nb, rd, er);
    chk("w3_rd_lat",  1, 32'(lat), 32'd4);
    chk("w3_rd",      1, 32'(rd),  32'hBEEF);

    // Out-of-range data accesses.
    access(0, 1'b0, 12'd16, 16'h0, lat, nb, rd, er);
    chk("oor_rd_err", 0, 32'(er), 32'd1);
    chk("oor_rd",     0, 32'(rd), 32'h0);
    access(0, 1'b1, 12'hFFF, 16'hDEAD, lat, nb, rd, er);
    chk("oor_wr_err", 0, 32'(er), 32'd1);
    chk("oor_wr_rd",  0, 32'(rd), 32'h0);
    access(0, 1'b0, 12'd15, 16'h0, lat, nb, rd, er);
    chk("oor_nowrite", 0, 32'(rd), 32'h000F);
    chk("mdl_dmem15",  0, 32'(mdm[0][15]), 32'h000F);

    // Two wait states, request held for three back-to-back writes.
    @(posedge clk); #1;
    dreq[2] = 1'b1; dwe[2] = 1'b1; daddr[2] = 12'd1; dwd[2] = 16'h00A1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!dack[2] && n < 20);
      chk("b2b_gap", 2, 32'(n), 32'd3);
      chk("b2b_rd",  2, 32'(drd[2]), 32'h00A1 + 32'(k));
      if (k < 2) begin
        daddr[2] = 12'(k + 2);
        dwd[2]   = 16'h00A2 + 16'(k);
      end else begin
        dreq[2] = 1'b0; dwe[2] = 1'b0;
      end
    end
    for (int a = 1; a <= 3; a++) begin
      access(2, 1'b0, 12'(a), 16'h0, lat, nb, rd, er);
      chk("b2b_readback", 2, 32'(rd), 32'h00A0 + 32'(a));
      chk("b2b_rd_lat",   2, 32'(lat), 32'd3);
    end

    // Reset in the middle of a waiting write.
    @(posedge clk); #1;
    dreq[1] = 1'b1; dwe[1] = 1'b1; daddr[1] = 12'd7; dwd[1] = 16'h5555;
    @(posedge clk); #1;
    chk("rstw_busy", 1, 32'(dbusy[1]), 32'h1);
    @(posedge clk); #2;
    rst = 1'b1; dreq[1] = 1'b0; dwe[1] = 1'b0;
    #1;
    chk("rstw_ack",   1, 32'(dack[1]),  32'h0);
    chk("rstw_busy0", 1, 32'(dbusy[1]), 32'h0);
    chk("rstw_rdata", 1, 32'(drd[1]),   32'h0);
    chk("rstw_ifv",   1, 32'(ifv[1]),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(1, 1'b0, 12'd7, 16'h0, lat, nb, rd, er);
    chk("rstw_dmem7", 1, 32'(rd),  32'h0007);
    chk("rstw_lat",   1, 32'(lat), 32'd4);
    chk("mdl_dmem7",  1, 32'(mdm[1][7]), 32'h7);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1);
  end

endmodule
